// File: rtl/alu_pkg.sv
// alu_pkg: shared AluOp codes, FSM encoding and op-class helper
// for the alu_seq EX-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REM   = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3] & (op[2] | op[1]);
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: single-cycle datapath for AluOp 0000-1001.
// Codes 0-7 keep the legacy 3-bit ALU behaviour.
module alu_seq_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] sh;

  assign sh = b[SHW-1:0];

  always_comb begin
    y = '0;
    unique case (1'b1)
      (op == OP_ADD):  y = a + b;
      (op == OP_SUB):  y = a - b;
      (op == OP_AND):  y = a & b;
      (op == OP_OR):   y = a | b;
      (op == OP_XOR):  y = a ^ b;
      (op == OP_SLL):  y = a << sh;
      (op == OP_SRL):  y = a >> sh;
      (op == OP_SLT):
        y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      (op == OP_SRA):  y = $signed(a) >>> sh;
      (op == OP_SLTU):
        y = {{(XLEN-1){1'b0}}, a < b};
      default:         y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage ALU, 1-cycle base ops plus
// bit-serial mul/div/rem when ALU_MULDIV_EN is defined.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      AluOp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            Illegal
);

  localparam int SHW = $clog2(XLEN);

  state_t          state;
  logic [XLEN-1:0] comb_y;

  alu_seq_comb #(.XLEN(XLEN)) u_comb (
    .a  (A),
    .b  (B),
    .op (AluOp),
    .y  (comb_y)
  );

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

`ifdef ALU_MULDIV_EN
  logic [XLEN-1:0] hi, lo, mc;
  logic [SHW:0]    cnt;
  logic [3:0]      op_q;
  logic            qneg, rneg;

  logic            sgn, a_neg, b_neg, ovf, bz, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_y;
  logic [XLEN:0]   sum, part, diff;
  logic            ge;
  logic [XLEN-1:0] hi_n, lo_n, fin_y;

  always_comb begin
    sgn   = (AluOp == OP_DIV) || (AluOp == OP_REM);
    a_neg = sgn & A[XLEN-1];
    b_neg = sgn & B[XLEN-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
    bz    = (B == '0);
    ovf   = sgn && (A == {1'b1, {(XLEN-1){1'b0}}}) && (&B);
    fast  = AluOp[2] && (bz || ovf);
    if (bz)
      fast_y = AluOp[1] ? A : '1;
    else
      fast_y = AluOp[1] ? '0 : A;
  end

  // hi/lo double as {rem, quotient} for div, {acc, multiplier} for mul
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    part = {hi, lo[XLEN-1]};
    diff = part - {1'b0, mc};
    ge   = (part >= {1'b0, mc});
    if (op_q[2]) begin
      hi_n = ge ? diff[XLEN-1:0] : part[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ge};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    fin_y = hi;
    unique case (1'b1)
      (op_q == OP_MUL):   fin_y = lo;
      (op_q == OP_MULHU): fin_y = hi;
      (op_q == OP_DIV):   fin_y = qneg ? -lo : lo;
      (op_q == OP_DIVU):  fin_y = lo;
      (op_q == OP_REM):   fin_y = rneg ? -hi : hi;
      default:            fin_y = hi;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      Result  <= '0;
      Zero    <= 1'b0;
      Illegal <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      mc      <= '0;
      cnt     <= '0;
      op_q    <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            Illegal <= 1'b0;
            if (!is_muldiv(AluOp)) begin
              Result <= comb_y;
              Zero   <= (comb_y == '0);
              state  <= S_DONE;
            end else if (fast) begin
              Result <= fast_y;
              Zero   <= (fast_y == '0);
              state  <= S_DONE;
            end else begin
              hi    <= '0;
              lo    <= AluOp[2] ? a_mag : B;
              mc    <= AluOp[2] ? b_mag : A;
              op_q  <= AluOp;
              qneg  <= a_neg ^ b_neg;
              rneg  <= a_neg;
              cnt   <= (SHW+1)'(XLEN);
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (cnt != '0) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt - 1'b1;
          end else begin
            Result <= fin_y;
            Zero   <= (fin_y == '0);
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      Result  <= '0;
      Zero    <= 1'b0;
      Illegal <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            // mul/div ops retire at once as illegal
            if (is_muldiv(AluOp)) begin
              Result  <= '0;
              Zero    <= 1'b1;
              Illegal <= 1'b1;
            end else begin
              Result  <= comb_y;
              Zero    <= (comb_y == '0);
              Illegal <= 1'b0;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus random checks of alu_seq against
// an arithmetic reference model; honours ALU_MULDIV_EN.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  AluOp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] Result;
  logic        Zero;
  logic        Illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .AluOp     (AluOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Illegal   (Illegal)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  function automatic bit is_fast(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (op < 4'd12) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 4'd12 || op == 4'd14) &&
           a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint unsigned p;
    int sa, sb;
    sa = a;
    sb = b;
    p = longint'({32'd0, a}) * longint'({32'd0, b});
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  return sa >>> b[4:0];
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input string tag,
                        input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] er;
    int exp_lat, n;
    bit md, rdy_low;
    md = (op >= 4'd10);
    er = ref_alu(op, a, b);
    exp_lat = 1;
    if (md && MD && !is_fast(op, a, b)) exp_lat = 33;
    if (md && !MD) er = 0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    AluOp = op;
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    rdy_low = 1'b1;
    while (!out_valid && n < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_res"}, {32'd0, Result}, {32'd0, er});
    chk({tag, "_zero"}, 64'(Zero), 64'(er == 0));
    chk({tag, "_ill"}, 64'(Illegal), 64'(md && !MD));
    chk({tag, "_irdy"}, 64'({rdy_low, in_ready}), 64'(2'b10));
  endtask

  task automatic wait_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit held;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_ov", 64'(out_valid), 0);
    chk("rst_res", {32'd0, Result}, 0);
    chk("rst_zero", 64'(Zero), 0);
    chk("rst_ill", 64'(Illegal), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_irdy", 64'(in_ready), 1);

    run_op("add", 4'd0, 32'd124, 32'd73);
    chk("add_val", {32'd0, Result}, 197);
    run_op("sub", 4'd1, 32'd124, 32'd73);
    run_op("mul", 4'd10, 32'd124, 32'd73);
    run_op("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div", 4'd12, -32'sd7, 32'd2);
    run_op("rem", 4'd14, -32'sd7, 32'd2);
    run_op("divu0", 4'd13, 32'd7, 32'd0);
    run_op("divovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("removf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("remu0", 4'd15, 32'd9, 32'd0);
    run_op("sra", 4'd8, 32'h8000_00F0, 32'h0000_0124);
    run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'd1);

    out_ready = 1'b0;
    run_op("bp", 4'd9, 32'd1, 32'hFFFF_FFFF);
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (Result != 1 || !out_valid || in_ready) held = 1'b0;
    end
    chk("bp_hold", 64'(held), 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel", 64'({out_valid, in_ready}), 64'(2'b01));

    flush = 1'b1;
    in_valid = 1'b1;
    AluOp = 4'd0;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    chk("fl_idle", 64'({out_valid, in_ready}), 64'(2'b01));

    if (MD) begin
      AluOp = 4'd12;
      A = 32'd100;
      B = 32'd7;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_cycles(4);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl_busy", 64'({out_valid, in_ready}), 64'(2'b01));
      held = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_valid) held = 1'b1;
      end
      chk("fl_noval", 64'(held), 0);
    end
    out_ready = 1'b0;
    run_op("fl_done", 4'd4, 32'h0F0F, 32'hFF00);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_dn", 64'({out_valid, in_ready}), 64'(2'b01));
    chk("fl_keep", {32'd0, Result}, 64'h0000_F00F);
    out_ready = 1'b1;
    run_op("fl_add", 4'd0, 32'd2, 32'd3);
    chk("fl_add5", {32'd0, Result}, 5);

    out_ready = 1'b0;
    AluOp = 4'd10;
    A = 32'd124;
    B = 32'd73;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_cycles(4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 64'({out_valid, Result, Zero, Illegal}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 64'(in_ready), 1);
    run_op("post_rst", 4'd0, 32'd124, 32'd73);

    for (int i = 0; i < 150; i++) begin
      run_op("rnd", 4'($urandom_range(0, 15)), pick(), pick());
    end

    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle 3-bit-op ALU; sits in the EX stage of the RV32 core.
- Executes the base ALU ops plus SRA/SLTU with one-cycle latency.
- Executes RV M-extension multiply/divide/remainder iteratively, one bit per cycle.
- Valid/ready on both sides so the pipeline can stall on multi-cycle ops.

Parameters:
- XLEN, 32, operand/result width; power of two, 8..64.
- SHW, $clog2(XLEN), localparam: shift-amount width; B[SHW-1:0] is the shift amount.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of any in-flight op
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept
- A  in  XLEN  operand A / dividend / multiplicand
- B  in  XLEN  operand B / divisor / multiplier / shift amount
- AluOp  in  4  operation code (see Behaviour)
- out_valid  out  1  Result valid
- out_ready  in  1  consumer takes Result
- Result  out  XLEN  registered result
- Zero  out  1  Result == 0, registered with Result
- Illegal  out  1  op not supported in this build

Behaviour:
- AluOp codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SLT (signed); codes 0-7 match the legacy 3-bit ALU.
  - 1000 SRA, 1001 SLTU, 1010 MUL (low XLEN), 1011 MULHU (high XLEN, unsigned).
  - 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU return 1 or 0, zero-extended.
  - Shifts use B[SHW-1:0] only.
- Reset (rst_n low, any time, including mid-operation):
  - state=IDLE.
  - out_valid=0, Result=0, Zero=0, Illegal=0, in_ready=1 after reset release.
  - Partial mul/div state is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance is in_valid && in_ready && !flush at a clock edge.
  - On acceptance of op 0000-1001 or a fast-path div case: Result latched at that edge, go to DONE. out_valid rises 1 cycle after acceptance.
  - On acceptance of 1010-1111 (non-fast-path): load iteration registers, count=XLEN, go to BUSY.
- BUSY:
  - in_ready=0.
  - One shift-add (mul) or restoring-subtract (div) step per cycle on magnitudes.
  - Signed DIV/REM: capture operand signs at accept. Quotient sign = sign(A) xor sign(B); remainder sign = sign(A). Correction applied on the final step.
  - When count reaches 0: Result written, go to DONE. out_valid is high exactly XLEN+1 cycles after the accept edge.
- DONE:
  - out_valid=1, in_ready=0.
  - Result, Zero and Illegal are held stable until out_valid && out_ready; then go to IDLE.
  - No same-cycle re-accept: max throughput is one op per 2 cycles.
- Div fast path (decided in IDLE, 1-cycle latency):
  - B==0: DIV/DIVU Result = all-ones; REM/REMU Result = A.
  - DIV/REM with A = most-negative and B = -1: DIV Result = A; REM Result = 0.
- flush:
  - In BUSY or DONE: go to IDLE next edge, out_valid=0, Result/Zero/Illegal unchanged.
  - In IDLE with in_valid high: no accept (flush wins).
- Back-pressure: out_ready low in DONE holds indefinitely; there is no timeout.
- Zero is recomputed whenever Result is written.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: ops 1010-1111 execute as above; Illegal is always 0.
- Undefined:
  - No iteration datapath is instantiated and the BUSY state is never entered.
  - Ops 1010-1111 complete in 1 cycle with Result=0, Zero=1, Illegal=1.
  - All other ops are unaffected.

Decomposition:
- Package alu_pkg:
  - localparams for the 16 AluOp codes.
  - FSM state encoding (2 bits).
  - Helper function is_muldiv(op).
- Sub-module alu_seq_comb: purely combinational single-cycle datapath for ops 0000-1001, parametrised on XLEN.
- The mul/div iteration and FSM stay in alu_seq.

Test Plan:
1. XLEN=32, A=124, B=73, ADD then SUB, out_ready=1.
   - ADD: Result=197, out_valid 1 cycle after accept.
   - SUB: Result=51, Zero=0.
2. MUL A=124, B=73: Result=9052 exactly 33 cycles after accept; in_ready=0 throughout BUSY. MULHU A=B=0xFFFFFFFF: Result=0xFFFFFFFE.
3. DIV/REM signed, A=-7, B=2: Quotient=-3 (0xFFFFFFFD), Remainder=-1 (0xFFFFFFFF); repeat with DIVU A=7, B=0.
   - DIVU B=0: Result=0xFFFFFFFF, 1-cycle latency.
   - DIV 0x80000000 / -1: Result=0x80000000, 1-cycle latency.
4. Back-pressure: SLTU A=1, B=0xFFFFFFFF, out_ready=0 for 10 cycles.
   - Result=1 held stable, out_valid=1, in_ready=0.
   - Release out_ready: IDLE the next cycle.
5. flush asserted 5 cycles into a DIV: IDLE next cycle, out_valid never rises. A new ADD 2+3 then returns 5. Repeat with rst_n pulsed low mid-BUSY: all outputs 0 immediately.
6. Build without ALU_MULDIV_EN: MUL 124*73 returns Result=0, Illegal=1 in 1 cycle; ADD still returns 197 with Illegal=0.
